conv_layer_loader: RTL and testbench
====================================

# conv_layer_loader

Upstream sequencer for a `conv_layer` instance in the CNN pipeline. It accepts a valid/ready stream of DATA_SIZE-bit words (IEEE-754 doubles, treated as opaque bits) and converts it into indexed write strobes: weights, then biases, then input activations. It then pulses the layer's `compute` and waits for its `output_valid` before reporting done. It replaces the host-driven `input_data`/`input_index`/`input_write_*` drive of the first convolution layer.

## Interface
- DATA_SIZE, 64, word width
- NUM_INPUTS, 1, input channels
- INPUT_DIM, 28, activation height = width
- NUM_OUTPUTS, 16, output channels
- KERNEL_DIM, 3, kernel height = width
- clk  input  1  clock, all state on rising edge
- reset  input  1  reset, asynchronous and active-low
- start  input  1  begin a load/compute job; sampled only in IDLE
- load_params  input  1  sampled with start:
  - 1 = load weights, biases and activations
  - 0 = load activations only
- in_data  input  DATA_SIZE  stream word
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a word this cycle
- write_data  output  DATA_SIZE  registered copy of the accepted word
- index3, index2, index1, index0  output  16 each  write index to the layer
- write_weights, write_bias, write_act  output  1 each  one-cycle write strobes, at most one high
- compute  output  1  one-cycle pulse to the layer
- layer_done  input  1  layer `output_valid`
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when the job completes

## Operation
- States: IDLE, LD_W, LD_B, LD_A, CMP, WAIT, FIN.
- IDLE:
  - start=1 and load_params=1 → LD_W.
  - start=1 and load_params=0 → LD_A.
- A word is accepted when in_valid && in_ready.
  - in_ready = 1 exactly in LD_W, LD_B and LD_A; it is a pure state decode.
- LD_W accepts NUM_OUTPUTS·NUM_INPUTS·KERNEL_DIM² words (default 144).
  - Index mapping: index3 = out channel, index2 = in channel, index1 = kernel row, index0 = kernel column.
  - index0 increments fastest; index3 slowest.
  - Last word → LD_B.
- LD_B accepts NUM_OUTPUTS words (default 16).
  - index0 = out channel; index3..index1 = 0.
  - Last word → LD_A.
- LD_A accepts NUM_INPUTS·INPUT_DIM² words (default 784).
  - index3 = 0, index2 = channel, index1 = row, index0 = column; row-major, channel slowest.
  - Last word → CMP.
- CMP: compute=1 for one cycle → WAIT.
- WAIT: hold until layer_done=1 → FIN. Sampling of layer_done starts the cycle after compute.
- FIN: done=1 for one cycle → IDLE.
- Counters:
  - Separate 16-bit counters for index0..index3, nested wrap.
  - Each counter clears to 0 on entry to each load state.
  - Counters do not advance on cycles with no accepted word (bubbles allowed anywhere).
- start while busy=1 is ignored; load_params is ignored outside IDLE.
- in_valid outside load states: word is not consumed and no strobe is issued.
- layer_done outside WAIT is ignored.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, all counters 0.
  - in_ready=0, write_* = 0, compute=0, done=0, busy=0.
  - write_data=0, index3..0=0.
- Reset asserted mid-job aborts immediately. Partially written layer memory is not cleaned.
- Write latency is 1 cycle: a word accepted in cycle N gives strobe, write_data and index registered at cycle N+1.
- Full rate: one word per cycle.
  - Phase boundaries insert no bubble for the sender.
  - The first LD_B word can be accepted in the cycle after the last LD_W word.
- Cycle counts:
  - start sampled at cycle S → in_ready=1 from S+1.
  - Last LD_A word accepted at cycle L → last write_act at L+1, in_ready=0 at L+1, compute=1 at L+2.
  - layer_done seen at cycle D → done=1 at D+1, busy=0 at D+2.
- busy rises the cycle after start is accepted.
- Minimum job with load_params=0 at full rate: 784 + 3 cycles + layer latency.

## Test plan
- Reset defaults: hold reset=0 with random in_valid/start → all outputs 0.
  - Release reset with in_valid=1 → in_ready stays 0 until start.
- Full load at rate 1, default parameters:
  - Send 944 words with values 0..943.
  - Check write_weights for words 0..143:
    - word 10 → index3=1, index2=0, index1=0, index0=1.
  - Check write_bias for words 144..159 with index0=0..15.
  - Check write_act for words 160..943:
    - word 160+29 → index1=1, index0=1.
  - compute pulses exactly once, 2 cycles after the last acceptance.
- Activations only (load_params=0):
  - No write_weights/write_bias strobes.
  - 784 write_act strobes.
  - Last word → index1=27, index0=27.
- Bubbles: in_valid toggling with a random 50% pattern → identical index/data sequence to the full-rate run; strobe count equals acceptance count.
- Handshake end:
  - layer_done held 0 for 100 cycles → busy stays 1, done=0.
  - layer_done=1 → done exactly one cycle later.
  - start during WAIT is ignored.
- Reset mid-LD_A after 300 words:
  - Outputs return to 0 asynchronously.
  - A new start (load_params=0) restarts indices at 0,0,0,0.

Source files
------------

// File: rtl/conv_layer_loader.sv
// Stream-to-strobe sequencer feeding a conv_layer: loads weights, biases and activations
// as indexed writes, then pulses compute and waits for the layer to finish.
module conv_layer_loader #(
    parameter int unsigned DATA_SIZE   = 64,
    parameter int unsigned NUM_INPUTS  = 1,
    parameter int unsigned INPUT_DIM   = 28,
    parameter int unsigned NUM_OUTPUTS = 16,
    parameter int unsigned KERNEL_DIM  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 load_params,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_SIZE-1:0] write_data,
    output logic [15:0]          index3,
    output logic [15:0]          index2,
    output logic [15:0]          index1,
    output logic [15:0]          index0,
    output logic                 write_weights,
    output logic                 write_bias,
    output logic                 write_act,
    output logic                 compute,
    input  logic                 layer_done,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        StIdle, StLdW, StLdB, StLdA, StCmp, StWait, StFin
    } state_e;

    localparam logic [15:0] KDim = 16'(KERNEL_DIM);
    localparam logic [15:0] IDim = 16'(INPUT_DIM);
    localparam logic [15:0] NIn  = 16'(NUM_INPUTS);
    localparam logic [15:0] NOut = 16'(NUM_OUTPUTS);

    state_e      state_q, state_d;
    logic [15:0] cnt0_q, cnt1_q, cnt2_q, cnt3_q;
    logic [15:0] cnt0_d, cnt1_d, cnt2_d, cnt3_d;
    logic [15:0] lim0, lim1, lim2, lim3;
    logic        wrap0, wrap1, wrap2, wrap3;
    logic        accept, last_word;

    assign in_ready = (state_q == StLdW) || (state_q == StLdB) || (state_q == StLdA);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);
    assign accept   = in_valid && in_ready;

    // Per-phase counter extents; unused dimensions collapse to 1 so they stay at 0.
    always_comb begin
        lim0 = 16'd1;
        lim1 = 16'd1;
        lim2 = 16'd1;
        lim3 = 16'd1;
        case (state_q)
            StLdW: begin
                lim0 = KDim;
                lim1 = KDim;
                lim2 = NIn;
                lim3 = NOut;
            end
            StLdB: lim0 = NOut;
            StLdA: begin
                lim0 = IDim;
                lim1 = IDim;
                lim2 = NIn;
            end
            default: ;
        endcase
    end

    assign wrap0     = (cnt0_q == lim0 - 16'd1);
    assign wrap1     = (cnt1_q == lim1 - 16'd1);
    assign wrap2     = (cnt2_q == lim2 - 16'd1);
    assign wrap3     = (cnt3_q == lim3 - 16'd1);
    assign last_word = wrap0 && wrap1 && wrap2 && wrap3;

    always_comb begin
        state_d = state_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        cnt3_d  = cnt3_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = load_params ? StLdW : StLdA;
                    cnt0_d  = '0;
                    cnt1_d  = '0;
                    cnt2_d  = '0;
                    cnt3_d  = '0;
                end
            end
            StLdW, StLdB, StLdA: begin
                if (accept) begin
                    if (last_word) begin
                        state_d = (state_q == StLdW) ? StLdB :
                                  (state_q == StLdB) ? StLdA : StCmp;
                        cnt0_d  = '0;
                        cnt1_d  = '0;
                        cnt2_d  = '0;
                        cnt3_d  = '0;
                    end else begin
                        cnt0_d = wrap0 ? '0 : cnt0_q + 16'd1;
                        if (wrap0) cnt1_d = wrap1 ? '0 : cnt1_q + 16'd1;
                        if (wrap0 && wrap1) cnt2_d = wrap2 ? '0 : cnt2_q + 16'd1;
                        if (wrap0 && wrap1 && wrap2) cnt3_d = cnt3_q + 16'd1;
                    end
                end
            end
            StCmp: state_d = StWait;
            // compute is still high on the first WAIT cycle; only look at layer_done after it.
            StWait: if (layer_done && !compute) state_d = StFin;
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt0_q        <= '0;
            cnt1_q        <= '0;
            cnt2_q        <= '0;
            cnt3_q        <= '0;
            write_data    <= '0;
            index0        <= '0;
            index1        <= '0;
            index2        <= '0;
            index3        <= '0;
            write_weights <= 1'b0;
            write_bias    <= 1'b0;
            write_act     <= 1'b0;
            compute       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt0_q        <= cnt0_d;
            cnt1_q        <= cnt1_d;
            cnt2_q        <= cnt2_d;
            cnt3_q        <= cnt3_d;
            write_weights <= accept && (state_q == StLdW);
            write_bias    <= accept && (state_q == StLdB);
            write_act     <= accept && (state_q == StLdA);
            compute       <= (state_q == StCmp);
            if (accept) begin
                write_data <= in_data;
                index0     <= cnt0_q;
                index1     <= cnt1_q;
                index2     <= cnt2_q;
                index3     <= cnt3_q;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_loader.sv
// Randomized bench for conv_layer_loader: a job-level timeline model predicts every output
// cycle by cycle from word numbers, and a negedge compare process checks the DUT against it.
module tb_conv_layer_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        load_params;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] write_data;
    logic [15:0] index3, index2, index1, index0;
    logic        write_weights, write_bias, write_act;
    logic        compute;
    logic        layer_done;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    conv_layer_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_params  (load_params),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .write_data   (write_data),
        .index3       (index3),
        .index2       (index2),
        .index1       (index1),
        .index0       (index0),
        .write_weights(write_weights),
        .write_bias   (write_bias),
        .write_act    (write_act),
        .compute      (compute),
        .layer_done   (layer_done),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: job word j (0..943) maps to a phase and indices by plain arithmetic.
    bit          m_busy = 0, m_load = 0, m_cmp = 0, m_wait = 0, m_armed = 0, m_fin = 0;
    int          m_k = 0, m_total = 0, m_off = 0;
    bit          e_ww = 0, e_wb = 0, e_wa = 0, e_cmp = 0, e_done = 0;
    logic [63:0] e_data = '0;
    logic [15:0] e_i3 = '0, e_i2 = '0, e_i1 = '0, e_i0 = '0;
    int          e_j = -1;

    task automatic predict_word(input int j, input logic [63:0] d);
        int a;
        e_j = j; e_data = d;
        e_i3 = 0; e_i2 = 0; e_i1 = 0; e_i0 = 0;
        if (j < 144) begin
            e_ww = 1;
            e_i0 = 16'(j % 3); e_i1 = 16'((j / 3) % 3); e_i2 = 0; e_i3 = 16'(j / 9);
        end else if (j < 160) begin
            e_wb = 1;
            e_i0 = 16'(j - 144);
        end else begin
            e_wa = 1;
            a = j - 160;
            e_i0 = 16'(a % 28); e_i1 = 16'((a / 28) % 28); e_i2 = 16'(a / 784);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_load = 0; m_cmp = 0; m_wait = 0; m_armed = 0; m_fin = 0; m_k = 0;
            e_ww = 0; e_wb = 0; e_wa = 0; e_cmp = 0; e_done = 0;
            e_data = '0; e_i3 = 0; e_i2 = 0; e_i1 = 0; e_i0 = 0; e_j = -1;
        end else begin
            e_ww = 0; e_wb = 0; e_wa = 0; e_cmp = 0; e_done = 0;
            if (m_fin) begin
                m_fin = 0; m_busy = 0;
            end else if (m_wait) begin
                if (m_armed && layer_done) begin
                    m_wait = 0; m_fin = 1; e_done = 1;
                end
                m_armed = 1;
            end else if (m_cmp) begin
                m_cmp = 0; e_cmp = 1; m_wait = 1; m_armed = 0;
            end else if (m_load) begin
                if (in_valid) begin
                    predict_word(m_off + m_k, in_data);
                    m_k++;
                    if (m_k == m_total) begin
                        m_load = 0; m_cmp = 1;
                    end
                end
            end else if (start) begin
                m_busy = 1; m_load = 1; m_k = 0;
                m_total = load_params ? 944 : 784;
                m_off   = load_params ? 0 : 160;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(m_load));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("compute", 64'(compute), 64'(e_cmp));
        chk("done", 64'(done), 64'(e_done));
        chk("write_weights", 64'(write_weights), 64'(e_ww));
        chk("write_bias", 64'(write_bias), 64'(e_wb));
        chk("write_act", 64'(write_act), 64'(e_wa));
        if (!reset || e_ww || e_wb || e_wa) begin
            chk("write_data", write_data, e_data);
            chk("index3", 64'(index3), 64'(e_i3));
            chk("index2", 64'(index2), 64'(e_i2));
            chk("index1", 64'(index1), 64'(e_i1));
            chk("index0", 64'(index0), 64'(e_i0));
        end
        // Hand-computed anchor points.
        if (e_ww && e_j == 10) begin
            chk("w10_index3", 64'(index3), 64'd1);
            chk("w10_index0", 64'(index0), 64'd1);
        end
        if (e_wa && e_j == 189) begin
            chk("a29_index1", 64'(index1), 64'd1);
            chk("a29_index0", 64'(index0), 64'd1);
        end
        if (e_wa && e_j == 943) begin
            chk("alast_index1", 64'(index1), 64'd27);
            chk("alast_index0", 64'(index0), 64'd27);
        end
    end

    // Drives one job; stop_after > 0 leaves it mid-load after that many words.
    task automatic run_job(input bit lp, input bit bubbles, input int lat, input int stop_after);
        int total, off, sent, iter;
        total = lp ? 944 : 784;
        off   = lp ? 0 : 160;
        if (stop_after > 0) total = stop_after;
        @(negedge clk);
        start = 1; load_params = lp; in_valid = 0;
        sent = 0; iter = 0;
        while (sent < total && iter < 20000) begin
            @(negedge clk);
            start = bubbles ? 1'($urandom_range(0, 1)) : 1'b0;
            load_params = 1'($urandom_range(0, 1));
            layer_done  = bubbles ? 1'($urandom_range(0, 1)) : 1'b0;
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? 64'(sent + off) : {$urandom, $urandom};
            if (in_valid) sent++;
            iter++;
        end
        if (sent < total) chk("load_iteration_budget", 64'(sent), 64'(total));
        if (stop_after > 0) return;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            layer_done = 0;
            start      = (i % 7 == 3);
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = {$urandom, $urandom};
        end
        @(negedge clk);
        start = 0; layer_done = 1;
        @(negedge clk);
        layer_done = 0;
        repeat (3) @(negedge clk);
        in_valid = 0;
    endtask

    initial begin
        reset = 0; start = 0; load_params = 0; in_data = '0; in_valid = 0; layer_done = 0;
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
            in_data  = {$urandom, $urandom};
        end
        @(negedge clk);
        start = 0; in_valid = 1;
        reset = 1;
        repeat (5) @(negedge clk);

        run_job(1'b1, 1'b0, 5, 0);
        run_job(1'b0, 1'b0, 100, 0);
        run_job(1'b1, 1'b1, 20, 0);

        run_job(1'b0, 1'b0, 0, 300);
        @(negedge clk);
        in_valid = 0;
        #2 reset = 0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        chk("async_rst_write_act", 64'(write_act), 64'd0);
        chk("async_rst_write_data", write_data, 64'd0);
        chk("async_rst_index0", 64'(index0), 64'd0);
        @(negedge clk);
        reset = 1;
        run_job(1'b0, 1'b0, 4, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
